perf_event_monitor: RTL and testbench

- Synthesizable, parametrised performance monitor for the pipelined CPU; replaces ad-hoc bench-side stall/flush counting.
- Counts a cycle total plus NUM_EVENTS qualified pipeline events (stall, flush, ...) over a bounded run window.
- Exposes a latched snapshot of cycle count, PC and all event counters as a valid/ready word stream for a bench or debug port.

---
 rtl/perf_event_monitor.sv | 70 +++++++
 tb/tb_perf_event_monitor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_event_monitor.sv
// perf_event_monitor: bounded-window cycle/event counters with a frozen snapshot streamed as valid/ready words
module perf_event_monitor #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int PC_WIDTH   = 32,
  parameter int MAX_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic [NUM_EVENTS-1:0] inhibit_i,
  input  logic [PC_WIDTH-1:0]   pc_i,
  input  logic                  snap_req_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CNT_WIDTH-1:0]  out_data_o,
  output logic [3:0]            out_idx_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int NW = NUM_EVENTS + 2;
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CNT_WIDTH-1:0] cycle_cnt, cyc_nxt;
  logic [CNT_WIDTH-1:0] evt_cnt [NUM_EVENTS];
  logic [CNT_WIDTH-1:0] shadow [NW];
  logic [3:0] idx;
  logic busy, hit_max;
  assign cyc_nxt = (cycle_cnt == CMAX) ? cycle_cnt : cycle_cnt + 1'b1;
  assign hit_max = (MAX_CYCLES != 0) && (cyc_nxt == CNT_WIDTH'(MAX_CYCLES));
  always_ff @(posedge clk_i) begin
    if (!rst_i || clear_i) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      for (int k = 0; k < NUM_EVENTS; k++) evt_cnt[k] <= '0;
    end else if (state == IDLE && start_i) begin
      state <= RUN;
    end else if (state == RUN && start_i) begin
      cycle_cnt <= cyc_nxt;
      for (int k = 0; k < NUM_EVENTS; k++)
        if (event_i[k] && !inhibit_i[k] && evt_cnt[k] != CMAX) evt_cnt[k] <= evt_cnt[k] + 1'b1;
      if (hit_max) state <= DONE;
    end
  end
  // Capture uses pre-edge counters, so a same-cycle clear still streams the old values
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      busy <= 1'b0;
      idx  <= '0;
      for (int k = 0; k < NW; k++) shadow[k] <= '0;
    end else if (!busy && snap_req_i) begin
      busy      <= 1'b1;
      idx       <= '0;
      shadow[0] <= cycle_cnt;
      shadow[1] <= CNT_WIDTH'(pc_i);
      for (int k = 0; k < NUM_EVENTS; k++) shadow[k+2] <= evt_cnt[k];
    end else if (busy && out_ready_i) begin
      busy <= idx != 4'(NW - 1);
      idx  <= (idx == 4'(NW - 1)) ? '0 : idx + 4'd1;
    end
  end
  assign out_valid_o = busy;
  assign busy_o      = busy;
  assign out_idx_o   = idx;
  assign out_data_o  = shadow[idx];
  assign done_o      = state == DONE;
endmodule

// File: tb/tb_perf_event_monitor.sv
// tb_perf_event_monitor: scoreboard bench for the performance monitor (default build plus a 4-bit saturating build)
module tb_perf_event_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0, start = 1'b0, clr = 1'b0, snap = 1'b0, ready = 1'b0;
  logic [3:0] ev = '0, inh = '0;
  logic [31:0] pc = '0;
  logic valid, busy, done;
  logic [31:0] data;
  logic [3:0] idx;
  logic s_rst = 1'b0, s_start = 1'b0, s_clr = 1'b0, s_snap = 1'b0, s_ready = 1'b0;
  logic [1:0] s_ev = '0, s_inh = '0;
  logic [3:0] s_pc = '0;
  logic s_valid, s_busy, s_done;
  logic [3:0] s_data, s_idx;
  int tests = 0, fails = 0;
  logic [31:0] exp_q [$];
  logic [3:0] idx_q [$];

  perf_event_monitor dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clr), .event_i(ev), .inhibit_i(inh),
    .pc_i(pc), .snap_req_i(snap), .out_valid_o(valid), .out_ready_i(ready), .out_data_o(data),
    .out_idx_o(idx), .busy_o(busy), .done_o(done));

  perf_event_monitor #(.NUM_EVENTS(2), .CNT_WIDTH(4), .PC_WIDTH(4), .MAX_CYCLES(0)) sat (
    .clk_i(clk), .rst_i(s_rst), .start_i(s_start), .clear_i(s_clr), .event_i(s_ev), .inhibit_i(s_inh),
    .pc_i(s_pc), .snap_req_i(s_snap), .out_valid_o(s_valid), .out_ready_i(s_ready), .out_data_o(s_data),
    .out_idx_o(s_idx), .busy_o(s_busy), .done_o(s_done));

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_snap(input logic [31:0] c, input logic [31:0] p, input logic [31:0] e0,
                           input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] w [6];
    w = '{c, p, e0, e1, e2, e3};
    for (int i = 0; i < 6; i++) begin exp_q.push_back(w[i]); idx_q.push_back(4'(i)); end
  endtask

  task automatic request_snap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
    tests++;
    if (busy !== 1'b1 || valid !== 1'b1) begin
      fails++;
      $display("FAIL snap_start busy=%b valid=%b want 1/1", busy, valid);
    end
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1,0,0,...
  task automatic drain(input int mode);
    int n = 0;
    logic pstall = 1'b0;
    logic [31:0] pd = '0, e;
    logic [3:0] pi = '0, ei;
    while (exp_q.size() > 0 && n < 200) begin
      ready = (mode == 0) ? 1'b1 : (n % 3 == 0);
      if (pstall) begin
        tests++;
        if (data !== pd || idx !== pi) begin
          fails++;
          $display("FAIL stall_stable data=%h idx=%0d want %h/%0d", data, idx, pd, pi);
        end
      end
      pstall = valid && !ready;
      pd = data;
      pi = idx;
      if (valid && ready) begin
        e = exp_q.pop_front();
        ei = idx_q.pop_front();
        tests++;
        if (data !== e || idx !== ei) begin
          fails++;
          $display("FAIL word data=%h idx=%0d want %h/%0d", data, idx, e, ei);
        end
      end
      tick();
      n++;
    end
    ready = 1'b0;
    if (n >= 200) begin
      fails++;
      tests++;
      $display("FAIL drain_timeout words_left=%0d want 0", exp_q.size());
      exp_q.delete();
      idx_q.delete();
    end
    tests++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      fails++;
      $display("FAIL busy_clear busy=%b valid=%b want 0/0", busy, valid);
    end
  endtask

  task automatic do_clear();
    start = 1'b0; ev = '0; inh = '0; clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    tests++;
    if ({valid, busy, done, idx, data} !== '0) begin
      fails++;
      $display("FAIL reset v=%b b=%b d=%b idx=%0d data=%h want all 0", valid, busy, done, idx, data);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_max_cycles();
    do_clear();
    ev = 4'b0001; start = 1'b1;
    tick();
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 63) begin
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL done_early done=%b want 0", done); end
      end
    end
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL done_at_64 done=%b want 1", done); end
    tick(5);
    pc = 32'hDEAD_BEEF;
    push_snap(64, 32'hDEAD_BEEF, 64, 0, 0, 0);
    request_snap();
    drain(0);
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL done_hold done=%b want 1", done); end
  endtask

  task automatic test_qualify();
    do_clear();
    start = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      ev = {1'b0, 1'b1, (i % 2 == 0), 1'b1};
      inh = {1'b0, 1'b1, 1'b0, (i == 2 || i == 5 || i == 7)};
      tick();
    end
    start = 1'b0; ev = 4'hF; inh = '0;
    tick(3);
    ev = '0;
    pc = 32'h0000_1234;
    push_snap(10, 32'h1234, 7, 5, 0, 0);
    request_snap();
    drain(0);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL qual_done done=%b want 0", done); end
  endtask

  task automatic test_backpressure();
    pc = 32'h0000_00A5;
    push_snap(10, 32'hA5, 7, 5, 0, 0);
    request_snap();
    drain(1);
  endtask

  task automatic test_back_to_back();
    pc = 32'h0000_0077;
    push_snap(10, 32'h77, 7, 5, 0, 0);
    request_snap();
    pc = 32'h0000_0099;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    tests++;
    if (idx !== 4'd0) begin fails++; $display("FAIL snap_during_busy idx=%0d want 0", idx); end
    drain(0);
    push_snap(10, 32'h99, 7, 5, 0, 0);
    request_snap();
    drain(1);
  endtask

  task automatic test_clear_collision();
    do_clear();
    start = 1'b1;
    tick();
    ev = 4'b1000;
    tick(30);
    ev = '0;
    pc = 32'h0000_0030;
    push_snap(30, 32'h30, 0, 0, 0, 30);
    snap = 1'b1; clr = 1'b1;
    tick();
    snap = 1'b0;
    tick();
    clr = 1'b0; start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL clear_no_abort busy=%b want 1", busy); end
    drain(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    push_snap(0, 32'h30, 0, 0, 0, 0);
    request_snap();
    drain(0);
  endtask

  task automatic test_reset_mid();
    do_clear();
    start = 1'b1;
    tick(6);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    rst = 1'b0;
    tick();
    tests++;
    if ({valid, busy, done, idx, data} !== '0) begin
      fails++;
      $display("FAIL reset_mid v=%b b=%b d=%b idx=%0d data=%h want all 0", valid, busy, done, idx, data);
    end
    rst = 1'b1;
    tick(4);
    start = 1'b0;
    pc = 32'h0000_0003;
    push_snap(3, 32'h3, 0, 0, 0, 0);
    request_snap();
    drain(0);
  endtask

  task automatic test_saturation();
    logic [3:0] want [4];
    int got = 0, n = 0;
    want = '{4'd15, 4'hA, 4'd15, 4'd0};
    s_rst = 1'b0;
    tick(2);
    s_rst = 1'b1; s_start = 1'b1; s_ev = 2'b01;
    tick(21);
    tests++;
    if (s_done !== 1'b0) begin fails++; $display("FAIL sat_done done=%b want 0", s_done); end
    s_start = 1'b0; s_ev = '0; s_pc = 4'hA; s_snap = 1'b1;
    tick();
    s_snap = 1'b0; s_ready = 1'b1;
    while (got < 4 && n < 20) begin
      if (s_valid) begin
        tests++;
        if (s_data !== want[got] || s_idx !== 4'(got)) begin
          fails++;
          $display("FAIL sat_word data=%0d idx=%0d want %0d/%0d", s_data, s_idx, want[got], got);
        end
        got++;
      end
      tick();
      n++;
    end
    s_ready = 1'b0;
    tests++;
    if (got != 4 || s_busy !== 1'b0) begin
      fails++;
      $display("FAIL sat_stream words=%0d busy=%b want 4/0", got, s_busy);
    end
  endtask

  initial begin
    test_reset();
    test_max_cycles();
    test_qualify();
    test_backpressure();
    test_back_to_back();
    test_clear_collision();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
